fwd_select_ctrl: RTL and testbench

Generates the 2-bit operand-select codes that drive the pipeline's 4:1 operand muxes, which pick between register-file data and the bypass paths. It tracks the destination register of every in-flight instruction across the EX, MEM and WB stages. It issues registered select codes aligned with the EX stage, and raises a load-use stall when a bypass cannot cover a hazard. It sits beside the ID/EX pipeline register and is the producer of the `op` inputs of the EX-stage operand muxes.

---
 rtl/fwd_select_ctrl_if.sv | 35 +++
 rtl/fwd_select_ctrl.sv | 98 +++++++++
 tb/tb_fwd_select_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/fwd_select_ctrl_if.sv
// +-------------------------------------------------------------------------+
// | fwd_select_ctrl_if : ID-stage hazard inputs and EX operand-select outputs|
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
`default_nettype none

interface fwd_select_ctrl_if;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_rs1_used;
  logic       id_rs2_used;
  logic [4:0] id_rd;
  logic       id_we;
  logic       id_is_load;
  logic       flush;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic       stall;
  logic       ex_valid;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_we, id_is_load, flush,
    input  fwd_a, fwd_b, stall, ex_valid
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_we, id_is_load, flush,
    output fwd_a, fwd_b, stall, ex_valid
  );
endinterface

`default_nettype wire

// File: rtl/fwd_select_ctrl.sv
// +-------------------------------------------------------------------------+
// | fwd_select_ctrl : EX operand bypass select codes and load-use stall      |
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
`default_nettype none

module fwd_select_ctrl (
  input  wire logic         clk,
  input  wire logic         rst_n,
  fwd_select_ctrl_if.slave  bus
);

  localparam logic [1:0] C_SEL_RF    = 2'd0;
  localparam logic [1:0] C_SEL_EXMEM = 2'd1;
  localparam logic [1:0] C_SEL_MEMWB = 2'd2;
  localparam logic [1:0] C_SEL_WBHLD = 2'd3;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       we;
    logic       ld;
  } trk_t;

  trk_t       ex_q, ex_d;
  trk_t       mem_q, mem_d;
  trk_t       wb_q, wb_d;
  logic [1:0] fwd_a_q, fwd_a_d;
  logic [1:0] fwd_b_q, fwd_b_d;

  logic [2:0] res_a;
  logic [2:0] res_b;
  logic       stall;

  function automatic logic f_writes(input trk_t e);
    return e.v & e.we & (e.rd != 5'd0);
  endfunction

  // Result is {load_use_hazard, select_code}; youngest matching stage wins.
  function automatic logic [2:0] f_resolve(input logic [4:0] rs, input logic used,
                                           input trk_t ex, input trk_t mem, input trk_t wb);
    logic [2:0] r;
    r = {1'b0, C_SEL_RF};
    if (used && rs != 5'd0) begin
      if (f_writes(ex) && ex.rd == rs)
        r = ex.ld ? {1'b1, C_SEL_RF} : {1'b0, C_SEL_EXMEM};
      else if (f_writes(mem) && mem.rd == rs)
        r = {1'b0, C_SEL_MEMWB};
      else if (f_writes(wb) && wb.rd == rs)
        r = {1'b0, C_SEL_WBHLD};
    end
    return r;
  endfunction

  always_comb begin
    res_a = f_resolve(bus.id_rs1, bus.id_rs1_used, ex_q, mem_q, wb_q);
    res_b = f_resolve(bus.id_rs2, bus.id_rs2_used, ex_q, mem_q, wb_q);
    stall = bus.id_valid & ~bus.flush & (res_a[2] | res_b[2]);
  end

  // MEM and WB always advance; a stall only turns the EX slot into a bubble.
  always_comb begin
    mem_d   = ex_q;
    wb_d    = mem_q;
    ex_d    = '0;
    fwd_a_d = C_SEL_RF;
    fwd_b_d = C_SEL_RF;
    if (bus.id_valid && !bus.flush && !stall) begin
      ex_d    = '{v: 1'b1, rd: bus.id_rd, we: bus.id_we, ld: bus.id_is_load};
      fwd_a_d = res_a[1:0];
      fwd_b_d = res_b[1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      fwd_a_q <= C_SEL_RF;
      fwd_b_q <= C_SEL_RF;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign bus.fwd_a    = fwd_a_q;
  assign bus.fwd_b    = fwd_b_q;
  assign bus.stall    = stall;
  assign bus.ex_valid = ex_q.v;

endmodule

`default_nettype wire

// File: tb/tb_fwd_select_ctrl.sv
// +-------------------------------------------------------------------------+
// | tb_fwd_select_ctrl : scoreboard bench for fwd_select_ctrl                |
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
`default_nettype none

module tb_fwd_select_ctrl;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_miss;

  // Expected {ex_valid, fwd_a, fwd_b} for the cycle after each ID slot.
  logic [4:0] sb[$];

  fwd_select_ctrl_if bus ();

  fwd_select_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      logic [4:0] e;
      e = sb.pop_front();
      check("ex_valid", {7'd0, bus.ex_valid}, {7'd0, e[4]});
      check("fwd_a", {6'd0, bus.fwd_a}, {6'd0, e[3:2]});
      check("fwd_b", {6'd0, bus.fwd_b}, {6'd0, e[1:0]});
    end
  end

  task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                       input logic we, input logic ld, input logic fl);
    bus.id_valid    = v;
    bus.id_rs1      = rs1;
    bus.id_rs1_used = u1;
    bus.id_rs2      = rs2;
    bus.id_rs2_used = u2;
    bus.id_rd       = rd;
    bus.id_we       = we;
    bus.id_is_load  = ld;
    bus.flush       = fl;
  endtask

  // One ID slot: hand-derived expected stall now and codes in the next (EX) cycle.
  task automatic issue(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                       input logic we, input logic ld, input logic fl,
                       input logic est, input logic [1:0] ea, input logic [1:0] eb);
    @(negedge clk);
    drive(v, rs1, u1, rs2, u2, rd, we, ld, fl);
    #1;
    check("stall", {7'd0, bus.stall}, {7'd0, est});
    sb.push_back({v & ~est & ~fl, ea, eb});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    rst_n  = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("rst_fwd_a", {6'd0, bus.fwd_a}, 8'd0);
    check("rst_fwd_b", {6'd0, bus.fwd_b}, 8'd0);
    check("rst_ex_valid", {7'd0, bus.ex_valid}, 8'd0);
    check("rst_stall", {7'd0, bus.stall}, 8'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back ALU pair
    issue(1, 1, 0, 2, 0, 5, 1, 0, 0, 0, 0, 0);
    issue(1, 5, 1, 6, 1, 10, 1, 0, 0, 0, 1, 0);
    idle(3);

    // Distance 2, 3, 4 on rs2
    issue(1, 1, 0, 2, 0, 7, 1, 0, 0, 0, 0, 0);
    issue(1, 1, 1, 2, 1, 12, 1, 0, 0, 0, 0, 0);
    issue(1, 1, 1, 7, 1, 13, 1, 0, 0, 0, 0, 2);
    idle(3);
    issue(1, 1, 0, 2, 0, 7, 1, 0, 0, 0, 0, 0);
    issue(1, 1, 1, 2, 1, 12, 1, 0, 0, 0, 0, 0);
    issue(1, 1, 1, 2, 1, 13, 1, 0, 0, 0, 0, 0);
    issue(1, 1, 1, 7, 1, 14, 1, 0, 0, 0, 0, 3);
    idle(3);
    issue(1, 1, 0, 2, 0, 7, 1, 0, 0, 0, 0, 0);
    issue(1, 1, 1, 2, 1, 12, 1, 0, 0, 0, 0, 0);
    issue(1, 1, 1, 2, 1, 13, 1, 0, 0, 0, 0, 0);
    issue(1, 1, 1, 2, 1, 14, 1, 0, 0, 0, 0, 0);
    issue(1, 1, 1, 7, 1, 15, 1, 0, 0, 0, 0, 0);
    idle(3);

    // Load-use: one stall, bubble, then MEM/WB bypass
    issue(1, 2, 1, 0, 0, 3, 1, 1, 0, 0, 0, 0);
    issue(1, 3, 1, 1, 1, 14, 1, 0, 0, 1, 0, 0);
    issue(1, 3, 1, 1, 1, 14, 1, 0, 0, 0, 2, 0);
    issue(1, 1, 1, 3, 1, 15, 1, 0, 0, 0, 0, 3);
    idle(3);

    // x0 destinations and unused sources
    issue(1, 1, 0, 2, 0, 0, 1, 0, 0, 0, 0, 0);
    issue(1, 0, 1, 0, 1, 16, 1, 0, 0, 0, 0, 0);
    issue(1, 1, 0, 2, 0, 0, 1, 1, 0, 0, 0, 0);
    issue(1, 0, 1, 0, 1, 16, 1, 0, 0, 0, 0, 0);
    issue(1, 1, 0, 2, 0, 8, 1, 1, 0, 0, 0, 0);
    issue(1, 8, 0, 8, 0, 17, 1, 0, 0, 0, 0, 0);
    idle(3);

    // Same rd in EX and MEM: youngest wins
    issue(1, 1, 0, 2, 0, 9, 1, 0, 0, 0, 0, 0);
    issue(1, 1, 0, 2, 0, 9, 1, 0, 0, 0, 0, 0);
    issue(1, 9, 1, 9, 1, 18, 1, 0, 0, 0, 1, 1);
    idle(3);

    // Flush together with a load-use hazard
    issue(1, 1, 0, 2, 0, 4, 1, 1, 0, 0, 0, 0);
    issue(1, 4, 1, 2, 0, 19, 1, 0, 1, 0, 0, 0);
    idle(3);

    // Asynchronous reset while stalling
    issue(1, 1, 0, 2, 0, 2, 1, 0, 0, 0, 0, 0);
    issue(1, 2, 1, 0, 0, 6, 1, 1, 0, 0, 1, 0);
    @(negedge clk);
    drive(1, 6, 1, 0, 0, 20, 1, 0, 0);
    #1;
    check("pre_rst_stall", {7'd0, bus.stall}, 8'd1);
    check("pre_rst_ex_valid", {7'd0, bus.ex_valid}, 8'd1);
    check("pre_rst_fwd_a", {6'd0, bus.fwd_a}, 8'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_stall", {7'd0, bus.stall}, 8'd0);
    check("arst_ex_valid", {7'd0, bus.ex_valid}, 8'd0);
    check("arst_fwd_a", {6'd0, bus.fwd_a}, 8'd0);
    check("arst_fwd_b", {6'd0, bus.fwd_b}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(1, 6, 1, 2, 1, 20, 1, 0, 0, 0, 0, 0);
    idle(2);

    repeat (2) @(posedge clk);
    #3;
    check("sb_drain", sb.size() > 255 ? 8'hff : 8'(sb.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
